flash_cmd_sequencer: RTL

- Sequences complete SPI NOR flash operations (read, page program, sector erase, status read) on top of the byte-level SPI engine.
- Accepts one command descriptor at a time and streams program/read data over AXI-Stream.
- Inserts WRITE_ENABLE before program/erase, then polls the status register until the write completes or a timeout expires.
- Sits between the host-side command logic and the SPI engine, so no host software drives raw opcode sequences.

---
 rtl/flash_cmd_pkg.sv | 38 +++
 rtl/flash_poll_timer.sv | 30 +++
 rtl/flash_cmd_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_cmd_pkg.sv
// Shared types and constants for the SPI NOR flash command sequencer.
// Opcodes common to every operation live here; per-op opcodes are top parameters.
package flash_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_READ   = 2'd0,
        CMD_PROG   = 2'd1,
        CMD_ERASE  = 2'd2,
        CMD_STATUS = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        RSP_OK       = 2'd0,
        RSP_TIMEOUT  = 2'd1,
        RSP_PAGE_ERR = 2'd2,
        RSP_SHORT    = 2'd3
    } rsp_status_t;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam int SR_WIP_BIT = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_WREN,
        S_OPC,
        S_ADDR0,
        S_ADDR1,
        S_ADDR2,
        S_RD_DATA,
        S_WR_DATA,
        S_POLL_CMD,
        S_POLL_RD,
        S_DONE
    } state_t;

endpackage

// File: rtl/flash_poll_timer.sv
// Busy-poll timeout: saturating down-counter, reloaded when a write/erase
// is issued; expired stays high once the budget has run out.
module flash_poll_timer
    import flash_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT = 50000000
) (
    input  logic clk,
    input  logic sreset,
    input  logic load,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (sreset) begin
            count <= '0;
        end else if (load) begin
            count <= W'(TIMEOUT);
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/flash_cmd_sequencer.sv
// Runs complete SPI NOR operations (read/program/erase/status) over a
// byte-level SPI engine, one byte in flight at a time.
module flash_cmd_sequencer
    import flash_cmd_pkg::*;
#(
    parameter int unsigned LEN_BITS     = 8,
    parameter int unsigned POLL_TIMEOUT = 50000000,
    parameter logic [7:0]  OP_READ      = 8'h03,
    parameter logic [7:0]  OP_PROG      = 8'h02,
    parameter logic [7:0]  OP_ERASE     = 8'h20
) (
    input  logic                clk,
    input  logic                sreset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [23:0]         cmd_addr,
    input  logic [LEN_BITS-1:0] cmd_len,
    output logic                rsp_valid,
    output logic [1:0]          rsp_status,
    output logic [7:0]          rsp_sr,
    output logic                s_axis_tready,
    input  logic                s_axis_tvalid,
    input  logic                s_axis_tlast,
    input  logic [7:0]          s_axis_tdata,
    input  logic                m_axis_tready,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    output logic [7:0]          m_axis_tdata,
    input  logic                m_spi_tready,
    output logic                m_spi_tvalid,
    output logic                m_spi_tlast,
    output logic [7:0]          m_spi_tdata,
    input  logic                s_spi_tvalid,
    input  logic [7:0]          s_spi_tdata
);

    localparam int PW = LEN_BITS + 9;

    state_t              state;
    cmd_op_t             op_r;
    logic [23:0]         addr_r;
    logic [LEN_BITS-1:0] len_r;
    logic [LEN_BITS:0]   cnt;
    logic                inflight;
    logic                short_r;
    logic                expired;
    logic                timer_load;
    logic                spi_busy;
    logic                rx_done;
    logic                last_byte;
    logic [PW-1:0]       page_end;
    logic                page_err;
    logic                tx_want;
    logic                tx_last;
    logic [7:0]          tx_byte;

    assign spi_busy   = m_spi_tvalid | inflight;
    assign rx_done    = inflight & s_spi_tvalid;
    assign last_byte  = (cnt == {1'b0, len_r});
    assign page_end   = PW'(addr_r[7:0]) + PW'(len_r);
    assign page_err   = (page_end > PW'(255));
    assign timer_load = (state == S_WREN) && rx_done;

    flash_poll_timer #(.TIMEOUT(POLL_TIMEOUT)) u_timer (
        .clk     (clk),
        .sreset  (sreset),
        .load    (timer_load),
        .expired (expired)
    );

    // Byte the current state wants on the SPI engine, if any.
    always_comb begin
        tx_want = 1'b0;
        tx_last = 1'b0;
        tx_byte = 8'h00;
        unique case (state)
            S_WREN: begin
                tx_want = 1'b1;
                tx_byte = OP_WREN;
                tx_last = 1'b1;
            end
            S_OPC: begin
                tx_want = 1'b1;
                unique case (op_r)
                    CMD_READ:  tx_byte = OP_READ;
                    CMD_PROG:  tx_byte = OP_PROG;
                    CMD_ERASE: tx_byte = OP_ERASE;
                    default:   tx_byte = OP_RDSR;
                endcase
            end
            S_ADDR0: begin
                tx_want = 1'b1;
                tx_byte = addr_r[23:16];
            end
            S_ADDR1: begin
                tx_want = 1'b1;
                tx_byte = addr_r[15:8];
            end
            S_ADDR2: begin
                tx_want = 1'b1;
                tx_byte = addr_r[7:0];
                tx_last = (op_r == CMD_ERASE);
            end
            S_RD_DATA: begin
                tx_want = !m_axis_tvalid;
                tx_last = last_byte;
            end
            S_WR_DATA: begin
                tx_want = s_axis_tready && s_axis_tvalid;
                tx_byte = s_axis_tdata;
                tx_last = last_byte || s_axis_tlast;
            end
            S_POLL_CMD: begin
                tx_want = 1'b1;
                tx_byte = OP_RDSR;
            end
            S_POLL_RD: begin
                tx_want = 1'b1;
                tx_last = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state         <= S_IDLE;
            op_r          <= CMD_READ;
            addr_r        <= '0;
            len_r         <= '0;
            cnt           <= '0;
            inflight      <= 1'b0;
            short_r       <= 1'b0;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_status    <= RSP_OK;
            rsp_sr        <= 8'h00;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= 8'h00;
            m_spi_tvalid  <= 1'b0;
            m_spi_tlast   <= 1'b0;
            m_spi_tdata   <= 8'h00;
        end else begin
            rsp_valid <= 1'b0;
            if (tx_want && !spi_busy) begin
                m_spi_tvalid <= 1'b1;
                m_spi_tdata  <= tx_byte;
                m_spi_tlast  <= tx_last;
            end
            if (m_spi_tvalid && m_spi_tready) begin
                m_spi_tvalid <= 1'b0;
                inflight     <= 1'b1;
            end
            if (rx_done) begin
                inflight <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_r      <= cmd_op_t'(cmd_op);
                        addr_r    <= cmd_addr;
                        len_r     <= cmd_len;
                        cnt       <= '0;
                        short_r   <= 1'b0;
                        cmd_ready <= 1'b0;
                        unique case (cmd_op_t'(cmd_op))
                            CMD_PROG:  state <= S_CHECK;
                            CMD_ERASE: state <= S_WREN;
                            default:   state <= S_OPC;
                        endcase
                    end
                end
                S_CHECK: begin
                    if (page_err) begin
                        state      <= S_DONE;
                        rsp_valid  <= 1'b1;
                        rsp_status <= RSP_PAGE_ERR;
                    end else begin
                        state <= S_WREN;
                    end
                end
                S_WREN: if (rx_done) state <= S_OPC;
                S_OPC: begin
                    if (rx_done) begin
                        state <= (op_r == CMD_STATUS) ? S_POLL_RD : S_ADDR0;
                    end
                end
                S_ADDR0: if (rx_done) state <= S_ADDR1;
                S_ADDR1: if (rx_done) state <= S_ADDR2;
                S_ADDR2: begin
                    if (rx_done) begin
                        unique case (op_r)
                            CMD_READ: state <= S_RD_DATA;
                            CMD_PROG: begin
                                state         <= S_WR_DATA;
                                s_axis_tready <= 1'b1;
                            end
                            default: state <= S_POLL_CMD;
                        endcase
                    end
                end
                S_RD_DATA: begin
                    if (rx_done) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= s_spi_tdata;
                        m_axis_tlast  <= last_byte;
                        cnt           <= cnt + (LEN_BITS+1)'(1);
                    end
                    if (m_axis_tvalid && m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        if (m_axis_tlast) begin
                            state      <= S_DONE;
                            rsp_valid  <= 1'b1;
                            rsp_status <= RSP_OK;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (s_axis_tready && s_axis_tvalid) begin
                        s_axis_tready <= 1'b0;
                        if (s_axis_tlast && !last_byte) short_r <= 1'b1;
                    end
                    // m_spi_tlast still describes the byte just echoed back.
                    if (rx_done) begin
                        if (m_spi_tlast) begin
                            state <= S_POLL_CMD;
                        end else begin
                            cnt           <= cnt + (LEN_BITS+1)'(1);
                            s_axis_tready <= 1'b1;
                        end
                    end
                end
                S_POLL_CMD: if (rx_done) state <= S_POLL_RD;
                S_POLL_RD: begin
                    if (rx_done) begin
                        rsp_sr <= s_spi_tdata;
                        if (op_r != CMD_STATUS && s_spi_tdata[SR_WIP_BIT] && !expired) begin
                            state <= S_POLL_CMD;
                        end else begin
                            state     <= S_DONE;
                            rsp_valid <= 1'b1;
                            if (op_r == CMD_STATUS) rsp_status <= RSP_OK;
                            else if (expired)       rsp_status <= RSP_TIMEOUT;
                            else if (short_r)       rsp_status <= RSP_SHORT;
                            else                    rsp_status <= RSP_OK;
                        end
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
